// File: rtl/accel_issue_arbiter.sv
// Two-requester round-robin front end for a fixed-latency, non-stallable datapath.
// Results return through per-requester FWFT FIFOs; credits keep the FIFOs from overflowing.
module accel_issue_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clkIn,
  input  logic                    rstIn,
  input  logic [2*DATA_WIDTH-1:0] reqAIn,
  input  logic [2*DATA_WIDTH-1:0] reqBIn,
  input  logic [1:0]              reqValidIn,
  output logic [1:0]              reqReadyOut,
  output logic [DATA_WIDTH-1:0]   dataAOut,
  output logic [DATA_WIDTH-1:0]   dataBOut,
  output logic                    validOut,
  input  logic [DATA_WIDTH-1:0]   resultIn,
  input  logic                    resultValidIn,
  output logic [2*DATA_WIDTH-1:0] respDataOut,
  output logic [1:0]              respValidOut,
  input  logic [1:0]              respReadyIn,
  output logic                    busyOut,
  output logic                    errorOut
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [1:0]            w_eligible;
  logic [1:0]            w_grant;
  logic [1:0]            w_pop;
  logic [1:0]            w_push;
  logic [1:0]            w_lost;
  logic [1:0]            w_credit_nz;
  logic                  w_accept;
  logic                  w_sel;
  logic                  w_tag_valid;
  logic                  w_tag_id;

  logic                  r_ptr;
  logic                  r_valid_out;
  logic                  r_issue_id;
  logic [DATA_WIDTH-1:0] r_data_a;
  logic [DATA_WIDTH-1:0] r_data_b;
  logic [LATENCY-1:0]    r_tag_valid;
  logic [LATENCY-1:0]    r_tag_id;
  logic                  r_error;

  // Pointer only breaks ties; a lone eligible requester always wins.
  always_comb begin
    w_grant = w_eligible;
    if (w_eligible == 2'b11) begin
      w_grant = r_ptr ? 2'b10 : 2'b01;
    end
  end

  assign w_accept    = |w_grant;
  assign w_sel       = w_grant[1];
  assign w_tag_valid = r_tag_valid[LATENCY-1];
  assign w_tag_id    = r_tag_id[LATENCY-1];

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      r_ptr       <= 1'b0;
      r_valid_out <= 1'b0;
      r_issue_id  <= 1'b0;
      r_data_a    <= '0;
      r_data_b    <= '0;
      r_error     <= 1'b0;
    end else begin
      r_valid_out <= w_accept;
      r_issue_id  <= w_sel;
      r_data_a    <= w_accept ? (w_sel ? reqAIn[2*DATA_WIDTH-1:DATA_WIDTH] : reqAIn[DATA_WIDTH-1:0]) : '0;
      r_data_b    <= w_accept ? (w_sel ? reqBIn[2*DATA_WIDTH-1:DATA_WIDTH] : reqBIn[DATA_WIDTH-1:0]) : '0;
      if (w_accept) begin
        r_ptr <= ~w_sel;
      end
      if (resultValidIn != w_tag_valid) begin
        r_error <= 1'b1;
      end
    end
  end

  // Stage LATENCY-1 lines up with the result expected from the datapath this cycle.
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      r_tag_valid <= '0;
      r_tag_id    <= '0;
    end else begin
      r_tag_valid[0] <= r_valid_out;
      r_tag_id[0]    <= r_issue_id;
      for (int k = 1; k < LATENCY; k++) begin
        r_tag_valid[k] <= r_tag_valid[k-1];
        r_tag_id[k]    <= r_tag_id[k-1];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
      logic [AW-1:0]         r_wr_ptr;
      logic [AW-1:0]         r_rd_ptr;
      logic [CW-1:0]         r_count;
      logic [CW-1:0]         r_credit;

      assign w_eligible[gi]  = reqValidIn[gi] & (r_credit < CW'(FIFO_DEPTH));
      assign w_push[gi]      = w_tag_valid & resultValidIn & (w_tag_id == 1'(gi));
      assign w_lost[gi]      = w_tag_valid & ~resultValidIn & (w_tag_id == 1'(gi));
      assign w_pop[gi]       = respValidOut[gi] & respReadyIn[gi];
      assign w_credit_nz[gi] = (r_credit != '0);

      assign respValidOut[gi] = (r_count != '0);
      assign respDataOut[gi*DATA_WIDTH +: DATA_WIDTH] = respValidOut[gi] ? r_mem[r_rd_ptr] : '0;

      always_ff @(posedge clkIn) begin
        if (w_push[gi]) begin
          r_mem[r_wr_ptr] <= resultIn;
        end
      end

      // A lost slot still holds a credit, so it is released here alongside pops.
      always_ff @(posedge clkIn) begin
        if (rstIn) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
          r_credit <= '0;
        end else begin
          if (w_push[gi]) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
          end
          if (w_pop[gi]) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
          end
          r_count  <= r_count + CW'(w_push[gi]) - CW'(w_pop[gi]);
          r_credit <= r_credit + CW'(w_grant[gi]) - CW'(w_pop[gi]) - CW'(w_lost[gi]);
        end
      end
    end
  endgenerate

  assign reqReadyOut = w_grant;
  assign dataAOut    = r_data_a;
  assign dataBOut    = r_data_b;
  assign validOut    = r_valid_out;
  assign busyOut     = (|w_credit_nz) | r_valid_out;
  assign errorOut    = r_error;

endmodule

// File: tb/tb_accel_issue_arbiter.sv
// Bench for accel_issue_arbiter: adder datapath model, per-requester scoreboard queues,
// and one task per scenario.
module tb_accel_issue_arbiter;

  localparam int DW    = 32;
  localparam int LAT   = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2*DW-1:0] reqAIn = '0;
  logic [2*DW-1:0] reqBIn = '0;
  logic [1:0]    reqValidIn = '0;
  logic [1:0]    reqReadyOut;
  logic [DW-1:0] dataAOut;
  logic [DW-1:0] dataBOut;
  logic          validOut;
  logic [DW-1:0] resultIn;
  logic          resultValidIn;
  logic [2*DW-1:0] respDataOut;
  logic [1:0]    respValidOut;
  logic [1:0]    respReadyIn = '0;
  logic          busyOut;
  logic          errorOut;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q0 [$];
  logic [DW-1:0] exp_q1 [$];
  logic [DW-1:0] exp_val;
  logic          delay_mode = 1'b0;
  logic          pv [0:LAT];
  logic [DW-1:0] pd [0:LAT];

  always #5 clk = ~clk;

  accel_issue_arbiter #(.DATA_WIDTH(DW), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clkIn(clk), .rstIn(rst),
    .reqAIn(reqAIn), .reqBIn(reqBIn), .reqValidIn(reqValidIn), .reqReadyOut(reqReadyOut),
    .dataAOut(dataAOut), .dataBOut(dataBOut), .validOut(validOut),
    .resultIn(resultIn), .resultValidIn(resultValidIn),
    .respDataOut(respDataOut), .respValidOut(respValidOut), .respReadyIn(respReadyIn),
    .busyOut(busyOut), .errorOut(errorOut)
  );

  // Adder datapath; delay_mode adds one extra stage to provoke misalignment.
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= LAT; k++) pv[k] <= 1'b0;
    end else begin
      pv[0] <= validOut;
      pd[0] <= dataAOut + dataBOut;
      for (int k = 1; k <= LAT; k++) begin
        pv[k] <= pv[k-1];
        pd[k] <= pd[k-1];
      end
    end
  end

  assign resultValidIn = delay_mode ? pv[LAT] : pv[LAT-1];
  assign resultIn      = delay_mode ? pd[LAT] : pd[LAT-1];

  // Scoreboard: push on accepted request, compare on every pop.
  always @(negedge clk) begin
    if (rst) begin
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      if (respValidOut[0] && respReadyIn[0]) begin
        checks++;
        if (exp_q0.size() == 0) begin
          failures++;
          $display("FAIL resp0_unexpected got=%h", respDataOut[DW-1:0]);
        end else begin
          exp_val = exp_q0.pop_front();
          if (respDataOut[DW-1:0] !== exp_val) begin
            failures++;
            $display("FAIL resp0_data got=%h exp=%h", respDataOut[DW-1:0], exp_val);
          end else $display("pop r0 data=%h", exp_val);
        end
      end
      if (respValidOut[1] && respReadyIn[1]) begin
        checks++;
        if (exp_q1.size() == 0) begin
          failures++;
          $display("FAIL resp1_unexpected got=%h", respDataOut[2*DW-1:DW]);
        end else begin
          exp_val = exp_q1.pop_front();
          if (respDataOut[2*DW-1:DW] !== exp_val) begin
            failures++;
            $display("FAIL resp1_data got=%h exp=%h", respDataOut[2*DW-1:DW], exp_val);
          end else $display("pop r1 data=%h", exp_val);
        end
      end
      if (reqValidIn[0] && reqReadyOut[0]) exp_q0.push_back(reqAIn[DW-1:0] + reqBIn[DW-1:0]);
      if (reqValidIn[1] && reqReadyOut[1]) exp_q1.push_back(reqAIn[2*DW-1:DW] + reqBIn[2*DW-1:DW]);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    reqValidIn = '0;
    respReadyIn = '0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({reqReadyOut, validOut, dataAOut, dataBOut} !== '0) begin
      failures++;
      $display("FAIL reset_issue got=%h exp=0", {reqReadyOut, validOut, dataAOut, dataBOut});
    end
    checks++;
    if ({respValidOut, respDataOut} !== '0) begin
      failures++;
      $display("FAIL reset_resp got=%h exp=0", {respValidOut, respDataOut});
    end
    checks++;
    if ({busyOut, errorOut} !== 2'b00) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00", {busyOut, errorOut});
    end
  endtask

  task automatic test_single();
    do_reset();
    respReadyIn = 2'b11;
    reqAIn = {32'h0, 32'h1};
    reqBIn = {32'h0, 32'h2};
    reqValidIn = 2'b01;
    #1;
    checks++;
    if (reqReadyOut !== 2'b01) begin
      failures++;
      $display("FAIL single_grant got=%b exp=01", reqReadyOut);
    end
    next_cycle();
    reqValidIn = 2'b00;
    #1;
    checks++;
    if ({validOut, dataAOut, dataBOut, busyOut} !== {1'b1, 32'h1, 32'h2, 1'b1}) begin
      failures++;
      $display("FAIL single_issue got v=%b a=%h b=%h busy=%b exp v=1 a=1 b=2 busy=1",
               validOut, dataAOut, dataBOut, busyOut);
    end
    for (int k = 1; k <= 7; k++) begin
      checks++;
      if (respValidOut !== ((k == 6) ? 2'b01 : 2'b00)) begin
        failures++;
        $display("FAIL single_latency k=%0d got=%b", k, respValidOut);
      end
      if (k == 6) begin
        checks++;
        if (respDataOut !== {32'h0, 32'h3}) begin
          failures++;
          $display("FAIL single_data got=%h exp=%h", respDataOut, {32'h0, 32'h3});
        end
      end
      next_cycle();
      #1;
    end
    checks++;
    if (busyOut !== 1'b0) begin
      failures++;
      $display("FAIL single_idle busy=%b exp=0", busyOut);
    end
  endtask

  task automatic test_alternate();
    logic [1:0] expg;
    do_reset();
    respReadyIn = 2'b11;
    for (int k = 0; k < 10; k++) begin
      reqValidIn = 2'b11;
      reqAIn = {$urandom, $urandom};
      reqBIn = {$urandom, $urandom};
      #1;
      expg = (k % 2 == 1) ? 2'b10 : 2'b01;
      checks++;
      if (reqReadyOut !== expg) begin
        failures++;
        $display("FAIL alt_grant k=%0d got=%b exp=%b", k, reqReadyOut, expg);
      end
      next_cycle();
    end
    reqValidIn = 2'b00;
    repeat (10) next_cycle();
    checks++;
    if (exp_q0.size() + exp_q1.size() != 0) begin
      failures++;
      $display("FAIL alt_drain left=%0d exp=0", exp_q0.size() + exp_q1.size());
    end
  endtask

  task automatic test_full();
    int cred0;
    int cred1;
    logic ptr;
    logic v1;
    logic e0;
    logic e1;
    logic [1:0] expg;
    logic hist1 [0:29];
    do_reset();
    respReadyIn = 2'b10;
    cred0 = 0;
    ptr = 1'b0;
    for (int c = 0; c < 30; c++) begin
      v1 = (c < 20);
      reqValidIn = {v1, 1'b1};
      reqAIn = {$urandom, $urandom};
      reqBIn = {$urandom, $urandom};
      cred1 = 0;
      for (int j = c - 6; j < c; j++) if (j >= 0 && hist1[j]) cred1++;
      e0 = (cred0 < DEPTH);
      e1 = v1 && (cred1 < DEPTH);
      expg = (e0 && e1) ? (ptr ? 2'b10 : 2'b01) : {e1, e0};
      #1;
      checks++;
      if (reqReadyOut !== expg) begin
        failures++;
        $display("FAIL full_grant c=%0d got=%b exp=%b", c, reqReadyOut, expg);
      end
      if (expg[0]) cred0++;
      hist1[c] = expg[1];
      if (expg != 2'b00) ptr = expg[0];
      next_cycle();
    end
    respReadyIn = 2'b11;
    reqValidIn = 2'b01;
    #1;
    checks++;
    if ({respValidOut, reqReadyOut} !== 4'b0100) begin
      failures++;
      $display("FAIL full_held got valid=%b ready=%b exp valid=01 ready=00", respValidOut, reqReadyOut);
    end
    next_cycle();
    respReadyIn = 2'b10;
    #1;
    checks++;
    if (reqReadyOut !== 2'b01) begin
      failures++;
      $display("FAIL full_regrant got=%b exp=01", reqReadyOut);
    end
    next_cycle();
    for (int j = 1; j <= 4; j++) begin
      #1;
      checks++;
      if (reqReadyOut !== 2'b00) begin
        failures++;
        $display("FAIL full_stall j=%0d got=%b exp=00", j, reqReadyOut);
      end
      next_cycle();
    end
    respReadyIn = 2'b11;
    #1;
    checks++;
    if ({resultValidIn, respValidOut, reqReadyOut} !== 5'b10100) begin
      failures++;
      $display("FAIL push_pop_cycle got=%b exp=10100", {resultValidIn, respValidOut, reqReadyOut});
    end
    next_cycle();
    respReadyIn = 2'b10;
    reqValidIn = 2'b00;
    #1;
    checks++;
    if (respValidOut !== 2'b01) begin
      failures++;
      $display("FAIL push_pop_after got=%b exp=01", respValidOut);
    end
    respReadyIn = 2'b11;
    repeat (8) next_cycle();
    checks++;
    if (exp_q0.size() != 0 || respValidOut !== 2'b00 || busyOut !== 1'b0) begin
      failures++;
      $display("FAIL full_drain left=%0d valid=%b busy=%b exp 0/00/0", exp_q0.size(), respValidOut, busyOut);
    end
  endtask

  task automatic test_error();
    do_reset();
    respReadyIn = 2'b11;
    delay_mode = 1'b1;
    reqAIn = {32'h0, 32'h5};
    reqBIn = {32'h0, 32'h6};
    reqValidIn = 2'b01;
    #1;
    checks++;
    if (reqReadyOut !== 2'b01) begin
      failures++;
      $display("FAIL err_grant got=%b exp=01", reqReadyOut);
    end
    next_cycle();
    reqValidIn = 2'b00;
    for (int k = 1; k <= 9; k++) begin
      #1;
      checks++;
      if (errorOut !== (k >= 6) || respValidOut !== 2'b00) begin
        failures++;
        $display("FAIL err_timing k=%0d err=%b valid=%b exp err=%b valid=00", k, errorOut, respValidOut, k >= 6);
      end
      next_cycle();
    end
    checks++;
    if (busyOut !== 1'b0) begin
      failures++;
      $display("FAIL err_credit_lost busy=%b exp=0", busyOut);
    end
    delay_mode = 1'b0;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    checks++;
    if ({errorOut, respValidOut, busyOut} !== 4'b0000) begin
      failures++;
      $display("FAIL err_reset got=%b exp=0000", {errorOut, respValidOut, busyOut});
    end
    reqValidIn = 2'b11;
    reqAIn = {$urandom, $urandom};
    reqBIn = {$urandom, $urandom};
    #1;
    checks++;
    if (reqReadyOut !== 2'b01) begin
      failures++;
      $display("FAIL ptr_after_reset got=%b exp=01", reqReadyOut);
    end
    next_cycle();
    reqValidIn = 2'b00;
    repeat (8) next_cycle();
    checks++;
    if (exp_q0.size() + exp_q1.size() != 0 || errorOut !== 1'b0) begin
      failures++;
      $display("FAIL err_recover left=%0d err=%b exp 0/0", exp_q0.size() + exp_q1.size(), errorOut);
    end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    respReadyIn = 2'b11;
    for (int c = 0; c < 3; c++) begin
      reqValidIn = 2'b11;
      reqAIn = {$urandom, $urandom};
      reqBIn = {$urandom, $urandom};
      next_cycle();
    end
    reqValidIn = 2'b00;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++;
      if (respValidOut !== 2'b00 || busyOut !== 1'b0) begin
        failures++;
        $display("FAIL inflight_flushed k=%0d valid=%b busy=%b exp 00/0", k, respValidOut, busyOut);
      end
      next_cycle();
    end
    reqAIn = {32'h7, 32'h0};
    reqBIn = {32'h8, 32'h0};
    reqValidIn = 2'b10;
    #1;
    checks++;
    if (reqReadyOut !== 2'b10) begin
      failures++;
      $display("FAIL inflight_grant got=%b exp=10", reqReadyOut);
    end
    next_cycle();
    reqValidIn = 2'b00;
    for (int k = 1; k <= 7; k++) begin
      #1;
      checks++;
      if (respValidOut !== ((k == 6) ? 2'b10 : 2'b00)) begin
        failures++;
        $display("FAIL inflight_latency k=%0d got=%b", k, respValidOut);
      end
      if (k == 6) begin
        checks++;
        if (respDataOut[2*DW-1:DW] !== 32'hF) begin
          failures++;
          $display("FAIL inflight_data got=%h exp=f", respDataOut[2*DW-1:DW]);
        end
      end
      next_cycle();
    end
    checks++;
    if (exp_q0.size() + exp_q1.size() != 0) begin
      failures++;
      $display("FAIL inflight_drain left=%0d exp=0", exp_q0.size() + exp_q1.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_full();
    test_error();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/accel_issue_arbiter.md
Name: accel_issue_arbiter

Overview:
- Shares one fixed-latency, non-stallable operand datapath (dataA/dataB/valid in, result/valid out; e.g. FP add/mul) between two requesters.
- Round-robin arbitration with valid/ready on each requester.
- Issues operand pairs to the datapath and tags each issue with its requester.
- Routes each result back to its owner through a per-requester response FIFO, using credits so a result always has buffer space when it arrives.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- LATENCY, 4, cycles from validOut high to the matching resultValidIn; must be >= 1.
- FIFO_DEPTH, 4, entries per response FIFO; power of two, >= 2.

Ports:
- clkIn  input  1  clock; all state updates on rising edge.
- rstIn  input  1  synchronous, active-high reset.
- reqAIn  input  2*DATA_WIDTH  operand A; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
- reqBIn  input  2*DATA_WIDTH  operand B, same slicing.
- reqValidIn  input  2  requester i presents an operand pair.
- reqReadyOut  output  2  grant; transfer occurs when reqValidIn[i] and reqReadyOut[i] are both high.
- dataAOut  output  DATA_WIDTH  operand A to the datapath.
- dataBOut  output  DATA_WIDTH  operand B to the datapath.
- validOut  output  1  issue strobe to the datapath.
- resultIn  input  DATA_WIDTH  datapath result.
- resultValidIn  input  1  datapath result strobe.
- respDataOut  output  2*DATA_WIDTH  FIFO head per requester, sliced as above.
- respValidOut  output  2  response FIFO i is non-empty.
- respReadyIn  input  2  requester i pops its FIFO head.
- busyOut  output  1  any credit nonzero or validOut high.
- errorOut  output  1  sticky result/tag misalignment flag.

Behaviour:
- Reset, synchronous while rstIn is high at a clock edge:
  - All outputs 0.
  - FIFOs empty, credits 0, tag pipeline cleared, round-robin priority pointer = requester 0, errorOut cleared.
  - A reset mid-operation discards all in-flight and buffered results.
  - The datapath shares rstIn, so no stale results arrive after reset.
- Credits:
  - credit[i] counts requester i's issued-but-unpopped results (in pipeline plus buffered); width clog2(FIFO_DEPTH)+1.
  - Increments on each accepted request. Decrements on each pop (respValidOut[i] and respReadyIn[i]).
  - Both in the same cycle: unchanged.
  - Invariant: credit[i] <= FIFO_DEPTH.
- Eligibility: eligible[i] = reqValidIn[i] and credit[i] < FIFO_DEPTH.
- Arbitration (combinational, same cycle):
  - At most one grant per cycle.
  - Only one requester eligible: it is granted.
  - Both eligible: the requester named by the pointer is granted.
  - After any grant to i, the pointer moves to the other requester (1-i). No grant: pointer holds.
  - reqReadyOut is low for any requester that is not eligible.
- Issue (registered): the accepted pair appears on dataAOut/dataBOut with validOut=1 on the next cycle. With no acceptance, validOut=0 and the data outputs are 0.
- Tag pipeline:
  - LATENCY-stage shift register of {valid, id}, loaded in the validOut cycle.
  - The stage output is the expected owner of the result arriving this cycle.
  - Required timing: resultValidIn exactly LATENCY cycles after the matching validOut.
- Result routing:
  - resultValidIn with a valid tag: push resultIn into FIFO[id]. Credit guarantees space, so no overflow check is needed.
  - resultValidIn with no valid tag: result dropped, errorOut set.
  - Valid tag with no resultValidIn: errorOut set, credit[id] decremented (the slot is lost).
  - errorOut stays high until reset.
- Response FIFOs:
  - First-word fall-through; respDataOut slice shows the head.
  - A push and a pop in the same cycle are both honoured.
  - Pushes are registered: a result is visible on respValidOut the cycle after resultValidIn.
- End-to-end latency, request accepted at cycle T: validOut at T+1, resultValidIn at T+1+LATENCY, respValidOut at T+2+LATENCY.
- Throughput: one issue per cycle across both requesters.
- Full: with credit[i]=FIFO_DEPTH, requester i stalls while the other requester may still be granted.

Test Plan:
- Single requester, LATENCY=4, datapath model = A+B: requester 0 sends (0x1,0x2) at T -> validOut at T+1 with dataAOut=0x1, dataBOut=0x2 -> respValidOut[0] at T+6 with data 0x3; respDataOut[1] slice and respValidOut[1] stay 0.
- Both requesters valid continuously, respReadyIn=11 -> grants alternate 0,1,0,1 starting with 0 after reset; each requester receives its own sums in issue order.
- respReadyIn[0]=0, requester 0 streams -> exactly 4 grants, then reqReadyOut[0]=0 while requester 1 keeps one grant per cycle; raising respReadyIn[0] for one cycle -> one new grant to requester 0.
- Push and pop on the same FIFO in the same cycle with credit=FIFO_DEPTH -> credit unchanged, ordering preserved, no loss.
- Datapath model delays one result by one cycle -> errorOut rises at the expected cycle and stays high; rstIn pulse -> errorOut=0, all FIFOs empty, pointer=0.
- Reset asserted with 3 results in flight -> no respValidOut after reset; the next request completes with the normal T+2+LATENCY timing.
